// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access unit: size and state encodings,
// plus the byte-enable helper that the memory side also uses.
package dm_pkg;

  typedef logic [1:0] size_t;

  localparam size_t SZ_BYTE = 2'd0;
  localparam size_t SZ_HALF = 2'd1;
  localparam size_t SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  // Byte-lane mask for an access of the given size at byte offset lo.
  function automatic logic [3:0] be_mask(input size_t size, input logic [1:0] lo);
    logic [3:0] mask;
    case (size)
      SZ_BYTE: mask = 4'b0001 << lo;
      SZ_HALF: mask = lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Illegal size or an access not naturally aligned to its size.
  function automatic logic is_bad_access(input size_t size, input logic [1:0] lo);
    return (size == 2'd3) ||
           ((size == SZ_HALF) && lo[0]) ||
           ((size == SZ_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/dm_store_align_if.sv
// CPU-side request/response and word-memory signals of the access unit.
interface dm_store_align_if
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  size_t             req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  // The access unit.
  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  // The pipeline plus memory driving the unit.
  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/dm_load_ext.sv
// Selects the addressed lane of a read word and sign/zero-extends it to 32 bits.
module dm_load_ext
  import dm_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  size_t       size_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select followed by extension according to size and signedness.
  always_comb begin
    byte_v = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_v = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o = rdata_i;
    case (size_i)
      SZ_BYTE: data_o = {{24{signed_i & byte_v[7]}}, byte_v};
      SZ_HALF: data_o = {{16{signed_i & half_v[15]}}, half_v};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/dm_store_align.sv
// Data-memory access unit: aligns sb/sh/sw onto a word memory and extends load data.
// One access in flight; the pipeline is stalled until the response pulse.
module dm_store_align
  import dm_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  dm_store_align_if.slave   bus
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e            state_q, state_d;
  logic              we_q, signed_q;
  size_t             size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [7:0]        cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              accept;
  logic              mem_active;
  logic [31:0]       ext_data;
  logic [31:0]       wdata_rep;

  dm_load_ext u_load_ext (
    .rdata_i   (bus.mem_rdata),
    .addr_lo_i (addr_q[1:0]),
    .size_i    (size_q),
    .signed_i  (signed_q),
    .data_o    (ext_data)
  );

  // Next-state logic: accept, issue, wait for ack or timeout, single response cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    accept  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          cnt_d   = 8'd0;
          rdata_d = 32'd0;
          err_d   = is_bad_access(bus.req_size, bus.req_addr[1:0]);
          state_d = err_d ? StResp : StIssue;
        end
      end
      StIssue, StWait: begin
        if (bus.mem_ack) begin
          rdata_d = we_q ? 32'd0 : ext_data;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (state_q == StIssue) begin
          state_d = StWait;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TimeoutCnt) begin
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, counter, response data and latched request fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 8'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= SZ_BYTE;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q     <= bus.req_we;
        signed_q <= bus.req_signed;
        size_q   <= bus.req_size;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
      end
    end
  end

  // Memory-side outputs are zero whenever no memory cycle is in progress.
  always_comb begin
    mem_active = (state_q == StIssue) || (state_q == StWait);
    case (size_q)
      SZ_BYTE: wdata_rep = {4{wdata_q[7:0]}};
      SZ_HALF: wdata_rep = {2{wdata_q[15:0]}};
      default: wdata_rep = wdata_q;
    endcase
  end

  assign bus.mem_req    = mem_active;
  assign bus.mem_we     = mem_active & we_q;
  assign bus.mem_addr   = mem_active ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus.mem_be     = mem_active ? be_mask(size_q, addr_q[1:0]) : 4'b0000;
  assign bus.mem_wdata  = mem_active ? wdata_rep : 32'd0;

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.stall      = (state_q != StIdle);
  assign bus.resp_valid = (state_q == StResp);
  assign bus.resp_err   = (state_q == StResp) & err_q;
  assign bus.resp_rdata = (state_q == StResp) ? rdata_q : 32'd0;

endmodule

// File: tb/tb_dm_store_align.sv
// Randomized bench for dm_store_align against an arithmetic reference model.
module tb_dm_store_align;
  localparam int unsigned TIMEOUT = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  dm_store_align_if #(.ADDR_W(32)) bus ();

  dm_store_align #(
    .TIMEOUT (TIMEOUT),
    .ADDR_W  (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: illegal size or misaligned access.
  function automatic bit model_err(input int size, input int unsigned a);
    return (size == 3) || (size == 1 && (a % 2) != 0) || (size == 2 && a != 0);
  endfunction

  function automatic logic [31:0] model_be(input int size, input int unsigned a);
    if (size == 0) return 32'(1 << a);
    if (size == 1) return 32'(3 << a);
    return 32'd15;
  endfunction

  function automatic logic [31:0] model_wdata(input int size, input logic [31:0] wd);
    if (size == 0) return (wd & 32'hFF) * 32'h01010101;
    if (size == 1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input int size, input bit sgn, input int unsigned a,
                                             input logic [31:0] rd);
    logic [31:0] v;
    if (size == 0) begin
      v = (rd >> (8 * a)) & 32'hFF;
      if (sgn && v >= 32'd128) v = v - 32'd256;
    end else if (size == 1) begin
      v = (rd >> (8 * a)) & 32'hFFFF;
      if (sgn && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // One access; d = cycles from mem_req rising to mem_ack (d > TIMEOUT means never).
  // Entered and left just after a rising edge.
  task automatic do_access(input bit we, input int size, input bit sgn, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd, input int d);
    bit          err;
    int          lat;
    int unsigned a;
    logic [31:0] exp_rdata;
    a   = addr % 4;
    err = model_err(size, a);
    if (err) lat = 1;
    else if (d <= int'(TIMEOUT)) lat = d + 2;
    else lat = int'(TIMEOUT) + 2;
    if (err || we || d > int'(TIMEOUT)) exp_rdata = 32'd0;
    else exp_rdata = model_load(size, sgn, a, rd);

    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = 2'(size);
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.mem_ack    = 1'b0;
    @(negedge clk);
    check_eq("req_ready_idle", 32'(bus.req_ready), 32'd1);
    check_eq("stall_idle", 32'(bus.stall), 32'd0);
    @(posedge clk);
    for (int n = 1; n <= lat; n++) begin
      #1;
      // Junk on the request side must be ignored while busy.
      bus.req_valid  = 1'($urandom);
      bus.req_we     = 1'($urandom);
      bus.req_size   = 2'($urandom);
      bus.req_signed = 1'($urandom);
      bus.req_addr   = $urandom;
      bus.req_wdata  = $urandom;
      bus.mem_ack    = !err && (n == d + 1);
      bus.mem_rdata  = rd;
      @(negedge clk);
      check_eq("resp_valid", 32'(bus.resp_valid), 32'(n == lat));
      check_eq("stall_busy", 32'(bus.stall), 32'd1);
      check_eq("req_ready_busy", 32'(bus.req_ready), 32'd0);
      check_eq("mem_req", 32'(bus.mem_req), 32'(!err && n < lat));
      if (!err && n < lat) begin
        check_eq("mem_addr", bus.mem_addr, addr & ~32'd3);
        check_eq("mem_be", 32'(bus.mem_be), model_be(size, a));
        check_eq("mem_we", 32'(bus.mem_we), 32'(we));
        check_eq("mem_wdata", bus.mem_wdata, model_wdata(size, wd));
      end
      if (n == lat) begin
        check_eq("resp_err", 32'(bus.resp_err), 32'(err || d > int'(TIMEOUT)));
        check_eq("resp_rdata", bus.resp_rdata, exp_rdata);
      end
      @(posedge clk);
    end
    #1;
    bus.req_valid = 1'b0;
    bus.mem_ack   = 1'b0;
  endtask

  // Idle cycle with a stray mem_ack that must be ignored.
  task automatic idle_cycle();
    bus.req_valid = 1'b0;
    bus.mem_ack   = 1'($urandom);
    bus.mem_rdata = $urandom;
    @(negedge clk);
    check_eq("idle_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_eq("idle_mem_req", 32'(bus.mem_req), 32'd0);
    check_eq("idle_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_eq("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check_eq("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check_eq("rst_stall", 32'(bus.stall), 32'd0);
    check_eq("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check_eq("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check_eq("rst_mem_addr", bus.mem_addr, 32'd0);
    check_eq("rst_mem_be", 32'(bus.mem_be), 32'd0);
    check_eq("rst_mem_wdata", bus.mem_wdata, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed cases.
    do_access(1'b1, 0, 1'b0, 32'h1003, 32'h000000AB, 32'h0, 1);  // sb
    do_access(1'b0, 0, 1'b1, 32'h2001, 32'h0, 32'h12803456, 0);   // lb, ack in issue cycle
    do_access(1'b0, 0, 1'b1, 32'h2002, 32'h0, 32'h12803456, 2);   // lb negative
    do_access(1'b0, 0, 1'b0, 32'h2002, 32'h0, 32'h12803456, 1);   // lbu
    do_access(1'b0, 1, 1'b1, 32'h2002, 32'h0, 32'h80017FFF, 3);   // lh
    do_access(1'b0, 1, 1'b0, 32'h2002, 32'h0, 32'h80017FFF, 0);   // lhu
    do_access(1'b0, 2, 1'b1, 32'h2000, 32'h0, 32'hDEADBEEF, 4);   // lw, ack on last wait cycle
    do_access(1'b1, 1, 1'b0, 32'h0001, 32'h1234, 32'h0, 0);       // misaligned sh
    do_access(1'b0, 3, 1'b0, 32'h0004, 32'h0, 32'h0, 0);          // illegal size
    do_access(1'b0, 2, 1'b0, 32'h0008, 32'h0, 32'h5555AAAA, 99);  // timeout
    idle_cycle();

    // Reset while waiting: abandon with no response.
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'd2;
    bus.req_addr   = 32'h100;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_eq("pre_rst_mem_req", 32'(bus.mem_req), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
    check_eq("mid_rst_mem_req", 32'(bus.mem_req), 32'd0);
    check_eq("mid_rst_stall", 32'(bus.stall), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("mid_rst_no_resp", 32'(bus.resp_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Random traffic, back-to-back with occasional idle cycles.
    for (int i = 0; i < 400; i++) begin
      int sz;
      sz = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2));
      do_access(1'($urandom), sz, 1'($urandom), $urandom, $urandom, $urandom,
                int'($urandom_range(0, TIMEOUT + 2)));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
